// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution controller: RV32I branch
// funct3 encodings, controller state encoding and the BHT counter type.
package branch_pkg;

    // RV32I conditional branch funct3 encodings
    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    // Controller states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVAL     = 2'd1,
        REDIRECT = 2'd2
    } state_e;

    // Two-bit saturating branch history counter; MSB is the prediction
    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t BHT_RESET = 2'b01;
    localparam bht_ctr_t BHT_MAX   = 2'b11;
    localparam bht_ctr_t BHT_MIN   = 2'b00;

    // funct3 values 010 and 011 are not branch encodings
    function automatic logic isIllegalFunct3(input logic [2:0] f3);
        return (f3 == 3'b010) || (f3 == 3'b011);
    endfunction

endpackage

// File: rtl/branch_resolve_ctrl_branchcomp.sv
// branchComp: single-cycle branch condition evaluator. Produces BrTaken
// for the six RV32I conditional branches when Branch is asserted; any
// other funct3 evaluates as not taken.
module branchComp
    import branch_pkg::*;
(
    input  logic        Branch,
    input  logic [2:0]  funct3,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        BrTaken
);

    // Compare the operands according to the branch type
    always_comb begin
        BrTaken = 1'b0;
        if (Branch) begin
            case (funct3)
                BEQ:     BrTaken = (A == B);
                BNE:     BrTaken = (A != B);
                BLT:     BrTaken = ($signed(A) <  $signed(B));
                BGE:     BrTaken = ($signed(A) >= $signed(B));
                BLTU:    BrTaken = (A <  B);
                BGEU:    BrTaken = (A >= B);
                default: BrTaken = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: accepts one conditional branch at a time, resolves
// it on registered operands via branchComp, trains a 2-bit BHT and raises
// a held redirect/flush toward fetch when the fetch prediction was wrong.
module branch_resolve_ctrl
    import branch_pkg::*;
#(
    parameter int BHT_IDX_W = 4,
    parameter int XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [2:0]      funct3_i,
    input  logic            pred_taken_i,
    input  logic [XLEN-1:0] pred_pc_i,
    output logic            pred_taken_o,
    output logic            resolved_valid_o,
    output logic            resolved_taken_o,
    output logic            illegal_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    input  logic            redirect_ready_i,
    output logic            flush_o,
    output logic [XLEN-1:0] mispredict_cnt_o
);

    localparam int BHT_ENTRIES = 1 << BHT_IDX_W;

    state_e              state_q;
    logic [XLEN-1:0]     pc_q;
    logic [XLEN-1:0]     imm_q;
    logic [XLEN-1:0]     rs1_q;
    logic [XLEN-1:0]     rs2_q;
    logic [2:0]          funct3_q;
    logic                predTaken_q;
    logic [XLEN-1:0]     redirectPc_q;
    logic [XLEN-1:0]     mispredictCnt_q;
    bht_ctr_t            bht_q [BHT_ENTRIES];

    logic                inEval;
    logic                brTaken;
    logic                illegal;
    logic                mispredict;
    logic [XLEN-1:0]     target;
    logic [BHT_IDX_W-1:0] updIdx;
    logic [BHT_IDX_W-1:0] rdIdx;
    logic                unused_predPc;

    branchComp u_branchComp (
        .Branch  (1'b1),
        .funct3  (funct3_q),
        .A       (rs1_q),
        .B       (rs2_q),
        .BrTaken (brTaken)
    );

    // Resolution decode from the captured branch: legality, target, mispredict
    always_comb begin
        inEval     = (state_q == EVAL);
        illegal    = isIllegalFunct3(funct3_q);
        target     = brTaken ? (pc_q + imm_q) : (pc_q + 32'd4);
        mispredict = (brTaken != predTaken_q) && !illegal;
        updIdx     = pc_q[BHT_IDX_W+1:2];
        rdIdx      = pred_pc_i[BHT_IDX_W+1:2];
    end

    // Only the index bits of the fetch PC address the table
    assign unused_predPc = ^{pred_pc_i[XLEN-1:BHT_IDX_W+2], pred_pc_i[1:0]};

    // Controller FSM: capture on accept, resolve in EVAL, hold redirect until taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            pc_q            <= '0;
            imm_q           <= '0;
            rs1_q           <= '0;
            rs2_q           <= '0;
            funct3_q        <= '0;
            predTaken_q     <= 1'b0;
            redirectPc_q    <= '0;
            mispredictCnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        pc_q        <= pc_i;
                        imm_q       <= imm_i;
                        rs1_q       <= rs1_i;
                        rs2_q       <= rs2_i;
                        funct3_q    <= funct3_i;
                        predTaken_q <= pred_taken_i;
                        state_q     <= EVAL;
                    end
                end
                EVAL: begin
                    if (mispredict) begin
                        redirectPc_q <= target;
                        if (mispredictCnt_q != '1) begin
                            mispredictCnt_q <= mispredictCnt_q + 32'd1;
                        end
                        state_q <= REDIRECT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                REDIRECT: begin
                    if (redirect_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // BHT training: legal branches move their counter toward the actual outcome
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= BHT_RESET;
            end
        end else if (inEval && !illegal) begin
            if (brTaken) begin
                if (bht_q[updIdx] != BHT_MAX) begin
                    bht_q[updIdx] <= bht_q[updIdx] + 2'd1;
                end
            end else begin
                if (bht_q[updIdx] != BHT_MIN) begin
                    bht_q[updIdx] <= bht_q[updIdx] - 2'd1;
                end
            end
        end
    end

    // Output decode; the resolve pulse is suppressed while reset is asserted
    always_comb begin
        req_ready_o      = rst_n && (state_q == IDLE);
        resolved_valid_o = rst_n && inEval;
        resolved_taken_o = rst_n && inEval && brTaken && !illegal;
        illegal_o        = rst_n && inEval && illegal;
        redirect_valid_o = (state_q == REDIRECT);
        flush_o          = (state_q == REDIRECT);
        redirect_pc_o    = redirectPc_q;
        mispredict_cnt_o = mispredictCnt_q;
        pred_taken_o     = bht_q[rdIdx][1];
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: handshake timing, resolution,
// redirect backpressure, BHT training/saturation, illegal funct3, reset abort.
module tb_branch_resolve_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] pc_i;
    logic [31:0] imm_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic [2:0]  funct3_i;
    logic        pred_taken_i;
    logic [31:0] pred_pc_i;
    logic        pred_taken_o;
    logic        resolved_valid_o;
    logic        resolved_taken_o;
    logic        illegal_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        redirect_ready_i;
    logic        flush_o;
    logic [31:0] mispredict_cnt_o;

    int checks = 0;
    int errors = 0;

    branch_resolve_ctrl #(.BHT_IDX_W(4), .XLEN(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .pc_i             (pc_i),
        .imm_i            (imm_i),
        .rs1_i            (rs1_i),
        .rs2_i            (rs2_i),
        .funct3_i         (funct3_i),
        .pred_taken_i     (pred_taken_i),
        .pred_pc_i        (pred_pc_i),
        .pred_taken_o     (pred_taken_o),
        .resolved_valid_o (resolved_valid_o),
        .resolved_taken_o (resolved_taken_o),
        .illegal_o        (illegal_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .redirect_ready_i (redirect_ready_i),
        .flush_o          (flush_o),
        .mispredict_cnt_o (mispredict_cnt_o)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present one branch for a single accept edge, then scramble the request
    // inputs; returns at the falling edge of the EVAL cycle
    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] imm,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] f3, input logic pred);
        pc_i         = pc;
        imm_i        = imm;
        rs1_i        = a;
        rs2_i        = b;
        funct3_i     = f3;
        pred_taken_i = pred;
        req_valid_i  = 1'b1;
        @(negedge clk);
        req_valid_i  = 1'b0;
        pc_i         = 32'hDEAD_BEEF;
        imm_i        = 32'h1234_5678;
        rs1_i        = 32'h0BAD_F00D;
        rs2_i        = 32'h7777_0001;
        funct3_i     = 3'b111;
        pred_taken_i = ~pred;
    endtask

    initial begin
        rst_n            = 1'b0;
        req_valid_i      = 1'b0;
        pc_i             = '0;
        imm_i            = '0;
        rs1_i            = '0;
        rs2_i            = '0;
        funct3_i         = '0;
        pred_taken_i     = 1'b0;
        pred_pc_i        = 32'h100;
        redirect_ready_i = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", req_ready_o, 0);
        checkOutput("rst_redirect", redirect_valid_o, 0);
        checkOutput("rst_cnt", mispredict_cnt_o, 0);
        checkOutput("rst_pred", pred_taken_o, 0);
        rst_n = 1'b1;
        #1;
        checkOutput("idle_ready", req_ready_o, 1);
        @(negedge clk);

        // BEQ 5==5 predicted not taken: mispredict to 0x120
        applyStimulus(32'h100, 32'h20, 32'd5, 32'd5, 3'b000, 1'b0);
        checkOutput("beq_resv", resolved_valid_o, 1);
        checkOutput("beq_taken", resolved_taken_o, 1);
        checkOutput("beq_illegal", illegal_o, 0);
        checkOutput("beq_eval_ready", req_ready_o, 0);
        checkOutput("beq_eval_pred", pred_taken_o, 0);
        @(negedge clk);
        checkOutput("beq_redir", redirect_valid_o, 1);
        checkOutput("beq_flush", flush_o, 1);
        checkOutput("beq_rpc", redirect_pc_o, 32'h120);
        checkOutput("beq_cnt", mispredict_cnt_o, 1);
        checkOutput("beq_resv_off", resolved_valid_o, 0);
        checkOutput("beq_bht", pred_taken_o, 1);
        @(negedge clk);
        checkOutput("beq_back_idle", req_ready_o, 1);
        checkOutput("beq_redir_off", redirect_valid_o, 0);

        // BLT -1 < 1 signed, predicted taken: correct, two cycles
        applyStimulus(32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, 3'b100, 1'b1);
        checkOutput("blt_taken", resolved_taken_o, 1);
        @(negedge clk);
        checkOutput("blt_idle", req_ready_o, 1);
        checkOutput("blt_noredir", redirect_valid_o, 0);
        checkOutput("blt_cnt", mispredict_cnt_o, 1);

        // BLTU 0xFFFFFFFF < 1 unsigned is false: redirect to pc+4 under backpressure
        redirect_ready_i = 1'b0;
        applyStimulus(32'h300, 32'h10, 32'hFFFF_FFFF, 32'd1, 3'b110, 1'b1);
        checkOutput("bltu_taken", resolved_taken_o, 0);
        checkOutput("bltu_resv", resolved_valid_o, 1);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_redir", redirect_valid_o, 1);
            checkOutput("bp_flush", flush_o, 1);
            checkOutput("bp_rpc", redirect_pc_o, 32'h304);
            checkOutput("bp_ready", req_ready_o, 0);
            @(negedge clk);
        end
        checkOutput("bp_cnt", mispredict_cnt_o, 2);
        redirect_ready_i = 1'b1;
        #1;
        checkOutput("bp_hs_ready", req_ready_o, 0);
        @(negedge clk);
        checkOutput("bp_after_ready", req_ready_o, 1);
        checkOutput("bp_after_redir", redirect_valid_o, 0);

        // Illegal funct3 010 predicted taken: no redirect, BHT untouched
        pred_pc_i = 32'h104;
        applyStimulus(32'h104, 32'h40, 32'd7, 32'd7, 3'b010, 1'b1);
        checkOutput("ill_flag", illegal_o, 1);
        checkOutput("ill_taken", resolved_taken_o, 0);
        checkOutput("ill_resv", resolved_valid_o, 1);
        @(negedge clk);
        checkOutput("ill_noredir", redirect_valid_o, 0);
        checkOutput("ill_cnt", mispredict_cnt_o, 2);
        checkOutput("ill_ready", req_ready_o, 1);
        checkOutput("ill_pred", pred_taken_o, 0);
        // One taken update from an untouched 01 must predict taken
        applyStimulus(32'h104, 32'h8, 32'd7, 32'd7, 3'b000, 1'b1);
        @(negedge clk);
        checkOutput("ill_bht_kept", pred_taken_o, 1);
        checkOutput("ill_cnt2", mispredict_cnt_o, 2);

        // Mispredict, then reset while in REDIRECT
        pred_pc_i        = 32'h100;
        redirect_ready_i = 1'b0;
        applyStimulus(32'h500, 32'h8, 32'd1, 32'd2, 3'b001, 1'b0);
        @(negedge clk);
        checkOutput("rr_redir", redirect_valid_o, 1);
        checkOutput("rr_rpc", redirect_pc_o, 32'h508);
        checkOutput("rr_cnt", mispredict_cnt_o, 3);
        checkOutput("rr_pred_pre", pred_taken_o, 1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rr_redir_off", redirect_valid_o, 0);
        checkOutput("rr_flush_off", flush_o, 0);
        checkOutput("rr_ready", req_ready_o, 0);
        checkOutput("rr_cnt0", mispredict_cnt_o, 0);
        checkOutput("rr_rpc0", redirect_pc_o, 0);
        checkOutput("rr_bht0", pred_taken_o, 0);
        pred_pc_i = 32'h104;
        #1;
        checkOutput("rr_bht1", pred_taken_o, 0);
        rst_n            = 1'b1;
        redirect_ready_i = 1'b1;
        @(negedge clk);

        // Three taken branches at 0x40 train 01 -> 10 -> 11 -> 11
        pred_pc_i = 32'h40;
        applyStimulus(32'h40, 32'h40, 32'd3, 32'd3, 3'b000, 1'b1);
        checkOutput("sat_same_cycle", pred_taken_o, 0);
        @(negedge clk);
        checkOutput("sat_after1", pred_taken_o, 1);
        applyStimulus(32'h40, 32'h40, 32'd3, 32'd3, 3'b000, 1'b1);
        checkOutput("sat_eval2", pred_taken_o, 1);
        @(negedge clk);
        applyStimulus(32'h40, 32'h40, 32'd3, 32'd3, 3'b000, 1'b1);
        @(negedge clk);
        checkOutput("sat_after3", pred_taken_o, 1);
        checkOutput("sat_cnt", mispredict_cnt_o, 0);
        // Not taken from 11 gives 10, still predicting taken
        applyStimulus(32'h40, 32'h40, 32'd3, 32'd3, 3'b001, 1'b1);
        checkOutput("nt1_taken", resolved_taken_o, 0);
        @(negedge clk);
        checkOutput("nt1_rpc", redirect_pc_o, 32'h44);
        checkOutput("nt1_cnt", mispredict_cnt_o, 1);
        checkOutput("nt1_pred", pred_taken_o, 1);
        @(negedge clk);
        // Second not taken gives 01
        applyStimulus(32'h40, 32'h40, 32'd3, 32'd3, 3'b001, 1'b0);
        @(negedge clk);
        checkOutput("nt2_pred", pred_taken_o, 0);
        checkOutput("nt2_redir", redirect_valid_o, 0);
        checkOutput("nt2_cnt", mispredict_cnt_o, 1);

        // Target arithmetic wraps modulo 2^32
        applyStimulus(32'hFFFF_FFFC, 32'h4, 32'd0, 32'd0, 3'b000, 1'b0);
        @(negedge clk);
        checkOutput("wrap_taken_rpc", redirect_pc_o, 32'h0);
        checkOutput("wrap_taken_cnt", mispredict_cnt_o, 2);
        @(negedge clk);
        applyStimulus(32'h800, 32'h40, 32'd5, 32'd3, 3'b110, 1'b1);
        @(negedge clk);
        checkOutput("bltu2_rpc", redirect_pc_o, 32'h804);
        @(negedge clk);
        applyStimulus(32'hFFFF_FFFC, 32'h100, 32'd1, 32'd2, 3'b101, 1'b1);
        checkOutput("wrap_bge_taken", resolved_taken_o, 0);
        @(negedge clk);
        checkOutput("wrap_nt_rpc", redirect_pc_o, 32'h0);
        checkOutput("wrap_nt_cnt", mispredict_cnt_o, 4);
        @(negedge clk);
        checkOutput("final_ready", req_ready_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
